// File: rtl/maze_pkg.sv
// Shared maze definitions: default side length, coordinate width and controller states.
package maze_pkg;
  localparam int MAZE_WIDTH = 64;
  localparam int COORD_W    = 6;
  localparam int ROWS       = 64;
  localparam int CNT_W      = 13;
  localparam int VISIT_MAX  = 4096;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SERVE  = 2'd1,
    FROZEN = 2'd2
  } maze_state_e;
endpackage

// File: rtl/maze_bitmap.sv
// Maze storage: 64x64 wall bits (row-wide write, registered bit read) and
// 64x64 visited bits (single-bit set, clear-all, combinational lookup).
module maze_bitmap import maze_pkg::*; (
  input  logic               clk,
  input  logic               wall_we,
  input  logic [COORD_W-1:0] wall_row,
  input  logic [ROWS-1:0]    wall_data,
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  input  logic               rd_en,
  output logic               rd_bit_p1,
  input  logic               vis_clr,
  input  logic               vis_set,
  output logic               vis_bit
);

  logic [ROWS-1:0] wall_mem [ROWS];
  logic [ROWS-1:0] vis_mem  [ROWS];

  always_ff @(posedge clk) begin
    if (wall_we)
      wall_mem[wall_row] <= wall_data;
    if (rd_en)
      rd_bit_p1 <= wall_mem[row][col];
  end

  always_ff @(posedge clk) begin
    if (vis_clr) begin
      for (int i = 0; i < ROWS; i++)
        vis_mem[i] <= '0;
    end else if (vis_set) begin
      vis_mem[row][col] <= 1'b1;
    end
  end

  assign vis_bit = vis_mem[row][col];

endmodule

// File: rtl/maze_mem.sv
// Maze memory controller: row-by-row load, solver read/visit service, freeze on done.
// Holds the FSM, load row counter, range checks and the visited-cell counter.
module maze_mem import maze_pkg::*; #(
  parameter int MAZE_WIDTH = maze_pkg::MAZE_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] row,
  input  logic [COORD_W-1:0] col,
  input  logic               maze_oe,
  input  logic               maze_we,
  output logic               maze_in,
  input  logic               done,
  input  logic               load_valid,
  input  logic [ROWS-1:0]    load_data,
  output logic               load_ready,
  output logic               mem_ready,
  output logic [CNT_W-1:0]   visit_count,
  output logic               finished
);

  localparam logic [COORD_W:0]   LIMIT     = (COORD_W+1)'(MAZE_WIDTH);
  localparam logic [COORD_W-1:0] LAST_ROW  = COORD_W'(MAZE_WIDTH - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(VISIT_MAX);
  localparam logic [ROWS-1:0]    ROW_MASK  = (MAZE_WIDTH >= ROWS) ? {ROWS{1'b1}}
                                           : ((64'd1 << MAZE_WIDTH) - 64'd1);

  maze_state_e        state, state_nxt;
  logic [COORD_W-1:0] row_cnt;
  logic               in_range, transfer, last_row;
  logic               rd_ok, wr_ok;
  logic               rd_force_p1, rd_bit_p1, vis_bit;

  assign in_range = ({1'b0, row} < LIMIT) && ({1'b0, col} < LIMIT);
  assign last_row = (row_cnt == LAST_ROW);
  assign transfer = load_valid && (state == LOAD);
  assign rd_ok    = in_range && (state != LOAD);
  assign wr_ok    = maze_we && in_range && (state == SERVE);

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    mem_ready  = 1'b0;
    finished   = 1'b0;
    unique case (state)
      LOAD: begin
        load_ready = 1'b1;
        if (load_valid && last_row)
          state_nxt = SERVE;
      end
      SERVE: begin
        mem_ready = 1'b1;
        if (done)
          state_nxt = FROZEN;
      end
      FROZEN: begin
        mem_ready = 1'b1;
        finished  = 1'b1;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= LOAD;
    else
      state <= state_nxt;
  end

  // Counter parks on the last row so a completed load never wraps back to row 0.
  always_ff @(posedge clk) begin
    if (rst)
      row_cnt <= '0;
    else if (transfer && !last_row)
      row_cnt <= row_cnt + 1'b1;
  end

  // Stage p1: reads outside the loaded maze report a wall.
  always_ff @(posedge clk) begin
    if (rst)
      rd_force_p1 <= 1'b1;
    else if (maze_oe)
      rd_force_p1 <= !rd_ok;
  end

  always_ff @(posedge clk) begin
    if (rst)
      visit_count <= '0;
    else if (wr_ok && !vis_bit && (visit_count != CNT_MAX))
      visit_count <= visit_count + 1'b1;
  end

  assign maze_in = rd_bit_p1 | rd_force_p1;

  maze_bitmap u_bitmap (
    .clk       (clk),
    .wall_we   (transfer && !rst),
    .wall_row  (row_cnt),
    .wall_data (load_data & ROW_MASK),
    .row       (row),
    .col       (col),
    .rd_en     (maze_oe && rd_ok && !rst),
    .rd_bit_p1 (rd_bit_p1),
    .vis_clr   (rst),
    .vis_set   (wr_ok && !rst),
    .vis_bit   (vis_bit)
  );

endmodule

// File: tb/tb_maze_mem.sv
// Bench for maze_mem: a 64-wide and an 8-wide instance, each checked every cycle
// against a cell-level model, plus directed literal expectations.
module tb_maze_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        oe  [2];
  logic        we  [2];
  logic        dn  [2];
  logic        lv  [2];
  logic [5:0]  r   [2];
  logic [5:0]  c   [2];
  logic [63:0] ld  [2];
  logic        mi  [2];
  logic        lr  [2];
  logic        mr  [2];
  logic        fin [2];
  logic [12:0] vc  [2];

  int checks = 0;
  int errors = 0;

  maze_mem dut0 (
    .clk(clk), .rst(rst[0]), .row(r[0]), .col(c[0]), .maze_oe(oe[0]), .maze_we(we[0]),
    .maze_in(mi[0]), .done(dn[0]), .load_valid(lv[0]), .load_data(ld[0]),
    .load_ready(lr[0]), .mem_ready(mr[0]), .visit_count(vc[0]), .finished(fin[0])
  );

  maze_mem #(.MAZE_WIDTH(8)) dut1 (
    .clk(clk), .rst(rst[1]), .row(r[1]), .col(c[1]), .maze_oe(oe[1]), .maze_we(we[1]),
    .maze_in(mi[1]), .done(dn[1]), .load_valid(lv[1]), .load_data(ld[1]),
    .load_ready(lr[1]), .mem_ready(mr[1]), .visit_count(vc[1]), .finished(fin[1])
  );

  // ---------------- reference model ----------------
  logic [63:0] m_wall [2][64];
  logic [63:0] m_vis  [2][64];
  int          m_rows [2];
  int          m_cnt  [2];
  bit          m_loaded [2];
  bit          m_frozen [2];
  bit          m_seen   [2] = '{1'b0, 1'b0};
  logic        m_mi     [2];

  function automatic int wid(input int k);
    return (k == 0) ? 64 : 8;
  endfunction

  function automatic logic [63:0] mask(input int k);
    return (wid(k) == 64) ? {64{1'b1}} : ((64'd1 << wid(k)) - 64'd1);
  endfunction

  function automatic bit in_rng(input int k);
    return (int'(r[k]) < wid(k)) && (int'(c[k]) < wid(k));
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        m_seen[k]   <= 1'b1;
        m_rows[k]   <= 0;
        m_cnt[k]    <= 0;
        m_loaded[k] <= 1'b0;
        m_frozen[k] <= 1'b0;
        m_mi[k]     <= 1'b1;
        for (int j = 0; j < 64; j++) m_vis[k][j] <= '0;
      end else if (!m_loaded[k]) begin
        if (lv[k]) begin
          m_wall[k][m_rows[k]] <= ld[k] & mask(k);
          if (m_rows[k] == wid(k) - 1) m_loaded[k] <= 1'b1;
          else m_rows[k] <= m_rows[k] + 1;
        end
        if (oe[k]) m_mi[k] <= 1'b1;
      end else begin
        if (oe[k]) m_mi[k] <= in_rng(k) ? m_wall[k][r[k]][c[k]] : 1'b1;
        if (we[k] && !m_frozen[k] && in_rng(k) && !m_vis[k][r[k]][c[k]]) begin
          m_vis[k][r[k]][c[k]] <= 1'b1;
          if (m_cnt[k] < 4096) m_cnt[k] <= m_cnt[k] + 1;
        end
        if (dn[k]) m_frozen[k] <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[w%0d]: got %0d expected %0d", nm, wid(k), act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m_seen[k]) begin
        chk("model_maze_in",     k, 16'(mi[k]),  16'(m_mi[k]));
        chk("model_load_ready",  k, 16'(lr[k]),  16'(!m_loaded[k]));
        chk("model_mem_ready",   k, 16'(mr[k]),  16'(m_loaded[k]));
        chk("model_finished",    k, 16'(fin[k]), 16'(m_frozen[k]));
        chk("model_visit_count", k, 16'(vc[k]),  16'(m_cnt[k]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic logic [63:0] pat(input int k, input int i);
    if (k == 1) return (i == 2) ? 64'hFFFF_FFFF_FFFF_FF04 : 64'hFFFF_FFFF_FFFF_FF00;
    case (i)
      1:       return 64'h2;
      3:       return 64'h10;
      5:       return 64'h1;
      9:       return 64'hFFFF_0000_1234_5678;
      default: return 64'h0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input int k, input int rr, input int cc, input bit rd, input bit wr);
    r[k]  = 6'(rr);
    c[k]  = 6'(cc);
    oe[k] = rd;
    we[k] = wr;
    step();
    oe[k] = 1'b0;
    we[k] = 1'b0;
  endtask

  task automatic load_rows(input int k, input int first, input int n, input bit gap);
    for (int i = first; i < first + n; i++) begin
      lv[k] = 1'b1;
      ld[k] = pat(k, i);
      step();
      if (gap) begin
        lv[k] = 1'b0;
        ld[k] = {64{1'b1}};
        step();
      end
    end
    lv[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; oe[k] = 1'b0; we[k] = 1'b0; dn[k] = 1'b0; lv[k] = 1'b0;
      r[k] = '0; c[k] = '0; ld[k] = '0;
    end
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      chk("reset_load_ready",  k, 16'(lr[k]),  16'd1);
      chk("reset_mem_ready",   k, 16'(mr[k]),  16'd0);
      chk("reset_maze_in",     k, 16'(mi[k]),  16'd1);
      chk("reset_visit_count", k, 16'(vc[k]),  16'd0);
      chk("reset_finished",    k, 16'(fin[k]), 16'd0);
      rst[k] = 1'b0;
    end

    // solver activity and done while still loading
    dn[0] = 1'b1;
    access(0, 5, 0, 1'b1, 1'b1);
    dn[0] = 1'b0;
    chk("load_read_wall", 0, 16'(mi[0]),  16'd1);
    chk("load_write_ign", 0, 16'(vc[0]),  16'd0);
    chk("load_done_ign",  0, 16'(fin[0]), 16'd0);

    // 64 rows with load_valid toggling
    load_rows(0, 0, 63, 1'b1);
    chk("mr_before_64th", 0, 16'(mr[0]), 16'd0);
    lv[0] = 1'b1;
    ld[0] = pat(0, 63);
    step();
    lv[0] = 1'b0;
    chk("mr_after_64th", 0, 16'(mr[0]), 16'd1);
    chk("lr_after_64th", 0, 16'(lr[0]), 16'd0);

    load_rows(1, 0, 8, 1'b0);
    chk("w8_mem_ready", 1, 16'(mr[1]), 16'd1);

    access(0, 5, 0, 1'b1, 1'b0);
    chk("rd_5_0", 0, 16'(mi[0]), 16'd1);
    access(0, 5, 1, 1'b1, 1'b0);
    chk("rd_5_1", 0, 16'(mi[0]), 16'd0);
    access(0, 5, 0, 1'b0, 1'b0);
    chk("hold_no_oe", 0, 16'(mi[0]), 16'd0);

    access(0, 3, 3, 1'b0, 1'b1);
    access(0, 3, 3, 1'b0, 1'b1);
    access(0, 3, 4, 1'b1, 1'b1);
    chk("rdwr_3_4", 0, 16'(mi[0]), 16'd1);
    chk("visits_2", 0, 16'(vc[0]), 16'd2);
    access(0, 9, 3, 1'b1, 1'b0);
    chk("rd_9_3", 0, 16'(mi[0]), 16'd1);
    access(0, 9, 0, 1'b1, 1'b0);
    chk("rd_9_0", 0, 16'(mi[0]), 16'd0);

    // load words offered while serving must not touch the maze
    lv[0] = 1'b1;
    ld[0] = {64{1'b1}};
    step();
    lv[0] = 1'b0;
    access(0, 5, 1, 1'b1, 1'b0);
    chk("serve_load_ign", 0, 16'(mi[0]), 16'd0);

    // 8-wide instance: range checks
    access(1, 2, 3, 1'b1, 1'b0);
    chk("w8_rd_2_3", 1, 16'(mi[1]), 16'd0);
    access(1, 9, 2, 1'b1, 1'b0);
    chk("w8_rd_9_2", 1, 16'(mi[1]), 16'd1);
    access(1, 2, 9, 1'b0, 1'b1);
    chk("w8_wr_2_9", 1, 16'(vc[1]), 16'd0);
    access(1, 2, 2, 1'b1, 1'b1);
    chk("w8_rd_2_2", 1, 16'(mi[1]), 16'd1);
    chk("w8_wr_2_2", 1, 16'(vc[1]), 16'd1);

    // freeze 8-wide instance
    dn[1] = 1'b1;
    step();
    dn[1] = 1'b0;
    chk("w8_finished", 1, 16'(fin[1]), 16'd1);
    access(1, 1, 1, 1'b1, 1'b1);
    chk("w8_frozen_cnt", 1, 16'(vc[1]),  16'd1);
    chk("w8_frozen_rd",  1, 16'(mi[1]),  16'd0);
    chk("w8_frozen_fin", 1, 16'(fin[1]), 16'd1);

    // visit every cell of the 64-wide maze
    for (int rr = 0; rr < 64; rr++)
      for (int cc = 0; cc < 64; cc++)
        access(0, rr, cc, 1'b0, 1'b1);
    chk("visits_full", 0, 16'(vc[0]), 16'd4096);
    access(0, 0, 0, 1'b0, 1'b1);
    chk("visits_sat", 0, 16'(vc[0]), 16'd4096);
    dn[0] = 1'b1;
    step();
    dn[0] = 1'b0;
    chk("w64_finished", 0, 16'(fin[0]), 16'd1);

    // reset mid-load forces a full reload
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    chk("rst_visits", 0, 16'(vc[0]),  16'd0);
    chk("rst_fin",    0, 16'(fin[0]), 16'd0);
    load_rows(0, 0, 30, 1'b0);
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    chk("rst30_load_ready", 0, 16'(lr[0]), 16'd1);
    chk("rst30_mem_ready",  0, 16'(mr[0]), 16'd0);
    load_rows(0, 0, 63, 1'b0);
    chk("reload_63", 0, 16'(mr[0]), 16'd0);
    load_rows(0, 63, 1, 1'b0);
    chk("reload_64", 0, 16'(mr[0]), 16'd1);
    access(0, 5, 0, 1'b1, 1'b0);
    chk("reload_rd_5_0", 0, 16'(mi[0]), 16'd1);
    access(0, 5, 1, 1'b1, 1'b0);
    chk("reload_rd_5_1", 0, 16'(mi[0]), 16'd0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maze_mem.md
MAZE_MEM -- requirements
Module: maze_mem

Interface
REQ-001 Parameter: MAZE_WIDTH, default 64, maze side length in cells; legal range 2..64.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 row  input  6  row index from the solver.
REQ-005 col  input  6  column index from the solver.
REQ-006 maze_oe  input  1  read enable, synchronous.
REQ-007 maze_we  input  1  write enable, synchronous; marks cell [row,col] visited.
REQ-008 maze_in  output  1  cell content: 1 = wall, 0 = free.
REQ-009 done  input  1  solver exit-found flag.
REQ-010 load_valid  input  1  load word valid.
REQ-011 load_data  input  64  one maze row; bit c = cell [load row, c], 1 = wall.
REQ-012 load_ready  output  1  block accepts a load word.
REQ-013 mem_ready  output  1  maze fully loaded and serving solver accesses.
REQ-014 visit_count  output  13  number of distinct cells marked visited.
REQ-015 finished  output  1  done observed; block frozen.

Function
REQ-016 FSM states: LOAD, SERVE, FROZEN; reset enters LOAD.
REQ-017 LOAD: load_ready = 1; a word transfers on a cycle with load_valid && load_ready.
REQ-018 LOAD: transferred words fill rows 0..MAZE_WIDTH-1 in order; a 6-bit row counter increments per transfer.
REQ-019 LOAD: bits at positions >= MAZE_WIDTH of load_data are ignored.
REQ-020 LOAD -> SERVE on the cycle after transfer of row MAZE_WIDTH-1; the row counter does not wrap.
REQ-021 SERVE: load_ready = 0; load_valid is ignored; mem_ready = 1.
REQ-022 Read: maze_oe = 1 at edge N sets registered maze_in = wall bit [row,col] from edge N; value is visible during cycle N+1.
REQ-023 maze_in holds its last value when maze_oe = 0.
REQ-024 Write: maze_we = 1 in SERVE sets visited[row][col] at the edge; the wall bitmap is never modified.
REQ-025 visit_count increments by 1 only when the written cell was previously unvisited; it saturates at 4095+1 = 4096.
REQ-026 maze_oe and maze_we asserted together: the read uses the same-edge wall bit, and the write is applied.
REQ-027 Out of range (row or col >= MAZE_WIDTH): a read returns maze_in = 1 and a write is ignored (no count change).
REQ-028 Solver access in LOAD: a read returns maze_in = 1 and a write is ignored.
REQ-029 SERVE -> FROZEN on an edge with done = 1.
REQ-030 FROZEN: writes are ignored; reads still serviced; visit_count held; finished = 1; exit only by rst.
REQ-031 done = 1 in LOAD is ignored.

Reset
REQ-032 With rst = 1 at an edge, the block enters LOAD with: row counter = 0, all visited bits = 0, visit_count = 0, maze_in = 1, load_ready = 1, mem_ready = 0, finished = 0.
REQ-033 rst during LOAD or SERVE discards loaded content; the maze must be reloaded in full.
REQ-034 rst has priority over every simultaneous load, read, or write.

Structure
REQ-035 Shared package maze_pkg SHALL contain MAZE_WIDTH, the coordinate width (6), and the FSM state encoding (LOAD, SERVE, FROZEN); the solver uses the same package.
REQ-036 Storage SHALL be one sub-module, maze_bitmap: 64x64 wall bits with row-wide write and registered single-bit read, plus 64x64 visited bits with single-bit set and clear-all.
REQ-037 maze_mem SHALL contain the FSM, row counter, range checks, and visit counter only.

Verification
REQ-038 Load 64 rows with row 5 = 64'h1, others 0, then read [5,0] -> maze_in = 1 one cycle after oe; read [5,1] -> 0.
REQ-039 Load with load_valid toggling every other cycle -> exactly 64 transfers; mem_ready rises the cycle after the 64th.
REQ-040 Write [3,3] twice, then write [3,4] -> visit_count = 2.
REQ-041 MAZE_WIDTH = 8: read [9,2] -> maze_in = 1; write [2,9] -> visit_count unchanged.
REQ-042 Assert done, then write [1,1] -> finished = 1, visit_count unchanged, read [1,1] still returns the wall bit.
REQ-043 rst after 30 load words -> load_ready = 1, mem_ready = 0, and a full 64-word reload is required before mem_ready rises.
